iniciador_caminho: RTL
======================

# iniciador_caminho

Host-side driver for the path-finding core. It accepts obstacle-map writes and path commands from a host over valid/ready streams, and drives the core's obstacle-write port and fonte/destino start pulse. It then collects the path nodes the core emits on `gma_read_data_out`/`gma_pronto_out` into a FIFO and returns them to the host as a framed stream. It sits between the host bus adapter and the path-finding top level.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH` (defines.vh): node address width.
- FIFO_DEPTH, 64: path FIFO entries; power of two, ≥ 4.
- TIMEOUT_CYCLES, 65535: maximum wait for the first `gma_pronto_in` (used only with the macro).
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  reset.
- obst_valid_in / obst_ready_out  in/out  1  host obstacle-write handshake.
- obst_addr_in  in  ADDR_WIDTH  obstacle cell address.
- obst_data_in  in  1  1 = blocked.
- cmd_valid_in / cmd_ready_out  in/out  1  host path-command handshake.
- cmd_fonte_in, cmd_destino_in  in  ADDR_WIDTH  source and destination.
- obstaculos_wr_enable_out  out  1  core obstacle write strobe.
- obstaculos_wr_addr_out  out  ADDR_WIDTH  core obstacle write address.
- obstaculos_wr_data_out  out  1  core obstacle write data.
- top_wr_fonte_out  out  1  core start pulse.
- top_addr_fonte_out, top_addr_destino_out  out  ADDR_WIDTH  registered fonte/destino.
- gma_read_data_in  in  ADDR_WIDTH  path node from core.
- gma_pronto_in  in  1  node valid from core.
- cam_valid_out / cam_ready_in  out/in  1  host path-stream handshake.
- cam_data_out  out  ADDR_WIDTH  path node (FIFO head).
- cam_last_out  out  1  final entry of the run.
- ocupado_out  out  1  state ≠ OCIOSO.
- erro_overflow_out, erro_truncado_out, erro_timeout_out  out  1  sticky error flags.

## Operation
- States and transitions:
  - OCIOSO → INICIAR on command handshake.
  - INICIAR → AGUARDAR after exactly 1 cycle.
  - AGUARDAR → COLETAR on first `gma_pronto_in`=1.
  - COLETAR → DRENAR on final entry.
  - DRENAR → OCIOSO when the FIFO is empty.
- Readiness: `obst_ready_out` = (OCIOSO). `cmd_ready_out` = (OCIOSO & !obst_valid_in); obstacle writes have priority.
- Obstacle handshake: registers addr/data and asserts `obstaculos_wr_enable_out` for 1 cycle, on the next cycle.
- Command handshake: latches fonte/destino onto `top_addr_*_out`, held until the next command; clears all error flags.
- INICIAR: `top_wr_fonte_out`=1 for exactly one cycle.
- Capture: every cycle with `gma_pronto_in`=1 in AGUARDAR/COLETAR captures one node. Nodes arrive destino-first, back to fonte.
- Final entry, from a captured node equal to `top_addr_fonte_out`: pushed with last=1, then DRENAR. Nodes after it are ignored.
- Early termination: `gma_pronto_in` falls in COLETAR before fonte is seen. Push sentinel {ADDR_WIDTH{1'b1}} with last=1, set `erro_truncado_out`, go to DRENAR.
- Non-final pushes are allowed only when occupancy < FIFO_DEPTH−1. Otherwise the node is dropped and `erro_overflow_out` is set. The reserved slot guarantees the final entry is always stored.
- FIFO is show-ahead: `cam_valid_out` = !empty; an entry pops when valid & ready. Push and pop in the same cycle are legal.

## Timing
- Reset (rst=1 at clock edge): state OCIOSO, FIFO empty, fonte/destino = 0.
- During reset every output is 0, including both ready outputs, which are forced low.
- Reset mid-run aborts immediately: no further start pulse, FIFO flushed, flags cleared.
- Command handshake at edge N: `top_wr_fonte_out` high in cycle N+1; AGUARDAR from N+2.
- Obstacle handshake at N: write strobe in cycle N+1. Back-to-back writes are 1 per cycle.
- Node sampled at edge M: `cam_valid_out` earliest in cycle M+1.
- `ocupado_out` goes high the cycle after the command handshake and low the cycle after the last pop.
- fonte == destino: first node equals fonte; a single entry with last=1.

## Configuration
- `INICIADOR_TIMEOUT_EN` defined:
  - A counter runs in AGUARDAR.
  - After TIMEOUT_CYCLES cycles without `gma_pronto_in`: set `erro_timeout_out`, push sentinel with last=1, go to DRENAR.
- Undefined: AGUARDAR waits indefinitely; `erro_timeout_out` is tied 0; no counter logic.

## Test plan
- Obstacle stream: 3 back-to-back writes (5,1), (6,1), (7,0) → write strobes in 3 consecutive cycles with matching addr/data, one cycle after each handshake.
- Command fonte=3, destino=9; core emits 9,8,4,3 → one start pulse; host receives 9,8,4,3 with last only on 3; errors 0.
- fonte=destino=12; core emits 12 → single entry 12, last=1.
- FIFO_DEPTH=4; core emits 10,11,12,13,14,2 (fonte=2) with cam_ready_in=0 → stored 10,11,12,2(last); `erro_overflow_out`=1.
- Core emits 9,8, then pronto drops (fonte=3) → entries 9,8,all-ones(last); `erro_truncado_out`=1. With macro and TIMEOUT_CYCLES=16 and no pronto → sentinel after 16 cycles, `erro_timeout_out`=1. A new command clears both flags.

Source files
------------

// File: rtl/iniciador_caminho.sv
// iniciador_caminho: host-side driver for the path-finding core.
// Forwards host obstacle writes to the core, launches a fonte/destino run,
// collects the path nodes the core emits (destino first, back to fonte) into a
// show-ahead FIFO and returns them to the host as a framed stream.
// Optional feature: define INICIADOR_TIMEOUT_EN to bound the wait for the
// first node; otherwise AGUARDAR waits indefinitely.
// ADDR_WIDTH mirrors the project-wide node address width.
module iniciador_caminho #(
  parameter int ADDR_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  obst_valid_in,
  output logic                  obst_ready_out,
  input  logic [ADDR_WIDTH-1:0] obst_addr_in,
  input  logic                  obst_data_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_fonte_in,
  input  logic [ADDR_WIDTH-1:0] cmd_destino_in,
  output logic                  obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
  output logic                  obstaculos_wr_data_out,
  output logic                  top_wr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
  input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
  input  logic                  gma_pronto_in,
  output logic                  cam_valid_out,
  input  logic                  cam_ready_in,
  output logic [ADDR_WIDTH-1:0] cam_data_out,
  output logic                  cam_last_out,
  output logic                  ocupado_out,
  output logic                  erro_overflow_out,
  output logic                  erro_truncado_out,
  output logic                  erro_timeout_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] SENTINELA = {ADDR_WIDTH{1'b1}};
  // Non-final entries stop one slot short so the final entry always fits.
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_invalid
    $error("iniciador_caminho: FIFO_DEPTH must be a power of two >= 4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIAR  = 3'd1,
    AGUARDAR = 3'd2,
    COLETAR  = 3'd3,
    DRENAR   = 3'd4
  } estado_t;

  estado_t                estado_q, estado_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   wr_data_q, wr_data_d;
  logic                   start_q, start_d;
  logic [ADDR_WIDTH-1:0]  fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0]  destino_q, destino_d;
  logic                   ovf_q, ovf_d;
  logic                   trunc_q, trunc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ADDR_WIDTH:0]    mem_q [FIFO_DEPTH];

  logic                   obst_hs_s;
  logic                   cmd_hs_s;
  logic                   push_s;
  logic [ADDR_WIDTH-1:0]  push_data_s;
  logic                   push_last_s;
  logic                   pop_s;
  logic                   drena_fim_s;
  logic [ADDR_WIDTH:0]    head_s;

`ifdef INICIADOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMITE = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;
`endif

  // Host handshakes; readiness is forced low while reset is asserted.
  assign obst_ready_out = !rst && (estado_q == OCIOSO);
  assign cmd_ready_out  = !rst && (estado_q == OCIOSO) && !obst_valid_in;
  assign obst_hs_s      = obst_valid_in && obst_ready_out;
  assign cmd_hs_s       = cmd_valid_in && cmd_ready_out;

  // Show-ahead FIFO head, zeroed when nothing is presented.
  assign head_s        = mem_q[rd_ptr_q];
  assign cam_valid_out = !rst && (count_q != {CNT_W{1'b0}});
  assign cam_data_out  = cam_valid_out ? head_s[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
  assign cam_last_out  = cam_valid_out ? head_s[ADDR_WIDTH] : 1'b0;
  assign pop_s         = cam_valid_out && cam_ready_in;
  // DRENAR never pushes, so the FIFO is empty next cycle exactly in these cases.
  assign drena_fim_s   = (count_q == {CNT_W{1'b0}}) || ((count_q == CNT_W'(1)) && pop_s);

  assign ocupado_out              = !rst && (estado_q != OCIOSO);
  assign obstaculos_wr_enable_out = wr_en_q;
  assign obstaculos_wr_addr_out   = wr_addr_q;
  assign obstaculos_wr_data_out   = wr_data_q;
  assign top_wr_fonte_out         = start_q;
  assign top_addr_fonte_out       = fonte_q;
  assign top_addr_destino_out     = destino_q;
  assign erro_overflow_out        = ovf_q;
  assign erro_truncado_out        = trunc_q;
`ifdef INICIADOR_TIMEOUT_EN
  assign erro_timeout_out         = tmo_flag_q;
`else
  assign erro_timeout_out         = 1'b0;
`endif

  // Next-state, core strobes, capture decisions and error flags.
  always_comb begin
    estado_d    = estado_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    fonte_d     = fonte_q;
    destino_d   = destino_q;
    ovf_d       = ovf_q;
    trunc_d     = trunc_q;
    push_s      = 1'b0;
    push_data_s = gma_read_data_in;
    push_last_s = 1'b0;
`ifdef INICIADOR_TIMEOUT_EN
    tmo_cnt_d   = {TMO_W{1'b0}};
    tmo_flag_d  = tmo_flag_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (obst_hs_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = obst_addr_in;
          wr_data_d = obst_data_in;
        end else if (cmd_hs_s) begin
          fonte_d   = cmd_fonte_in;
          destino_d = cmd_destino_in;
          start_d   = 1'b1;
          ovf_d     = 1'b0;
          trunc_d   = 1'b0;
`ifdef INICIADOR_TIMEOUT_EN
          tmo_flag_d = 1'b0;
`endif
          estado_d  = INICIAR;
        end else begin
          estado_d  = OCIOSO;
        end
      end
      INICIAR: begin
        estado_d = AGUARDAR;
      end
      AGUARDAR, COLETAR: begin
        if (gma_pronto_in) begin
          if (gma_read_data_in == fonte_q) begin
            push_s      = 1'b1;
            push_last_s = 1'b1;
            estado_d    = DRENAR;
          end else begin
            estado_d = COLETAR;
            if (count_q < LIMITE) begin
              push_s = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (estado_q == COLETAR) begin
          // Core stopped before reaching fonte: close the frame with the sentinel.
          push_s      = 1'b1;
          push_data_s = SENTINELA;
          push_last_s = 1'b1;
          trunc_d     = 1'b1;
          estado_d    = DRENAR;
        end else begin
`ifdef INICIADOR_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LIMITE) begin
            push_s      = 1'b1;
            push_data_s = SENTINELA;
            push_last_s = 1'b1;
            tmo_flag_d  = 1'b1;
            estado_d    = DRENAR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`else
          estado_d = AGUARDAR;
`endif
        end
      end
      DRENAR: begin
        if (drena_fim_s) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = DRENAR;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_WIDTH{1'b0}};
      wr_data_q <= 1'b0;
      start_q   <= 1'b0;
      fonte_q   <= {ADDR_WIDTH{1'b0}};
      destino_q <= {ADDR_WIDTH{1'b0}};
      ovf_q     <= 1'b0;
      trunc_q   <= 1'b0;
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
`ifdef INICIADOR_TIMEOUT_EN
      tmo_cnt_q  <= {TMO_W{1'b0}};
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      fonte_q   <= fonte_d;
      destino_q <= destino_d;
      ovf_q     <= ovf_d;
      trunc_q   <= trunc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef INICIADOR_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {push_last_s, push_data_s};
    end
  end

endmodule
